// File: rtl/ami_tg.sv
// ami_tg: AXI4 master traffic generator; fills a window with a seeded pattern, reads it back and checks every beat.
// Defining AMI_TG_TIMEOUT_EN adds a 12-bit watchdog that aborts a run stalled on any channel.
module ami_tg #(
    parameter int                AXI_DW    = 128,
    parameter int                AXI_AW    = 32,
    parameter int                AXI_IW    = 4,
    parameter logic [AXI_AW-1:0] BASE_ADDR = '0,
    parameter int                WIN_BYTES = 1024,
    parameter int                BURST_LEN = 16
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                start,
    input  logic [31:0]         seed,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [15:0]         err_cnt,
    output logic [AXI_IW-1:0]   AWID,
    output logic [AXI_AW-1:0]   AWADDR,
    output logic [7:0]          AWLEN,
    output logic [2:0]          AWSIZE,
    output logic [1:0]          AWBURST,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [AXI_DW-1:0]   WDATA,
    output logic [AXI_DW/8-1:0] WSTRB,
    output logic                WLAST,
    output logic                WVALID,
    input  logic                WREADY,
    input  logic [AXI_IW-1:0]   BID,
    input  logic [1:0]          BRESP,
    input  logic                BVALID,
    output logic                BREADY,
    output logic [AXI_IW-1:0]   ARID,
    output logic [AXI_AW-1:0]   ARADDR,
    output logic [7:0]          ARLEN,
    output logic [2:0]          ARSIZE,
    output logic [1:0]          ARBURST,
    output logic                ARVALID,
    input  logic                ARREADY,
    input  logic [AXI_IW-1:0]   RID,
    input  logic [AXI_DW-1:0]   RDATA,
    input  logic [1:0]          RRESP,
    input  logic                RLAST,
    input  logic                RVALID,
    output logic                RREADY
);
    localparam int BB = BURST_LEN * AXI_DW / 8;
    localparam int NB = WIN_BYTES / BB;
    localparam logic [15:0] LAST_N = 16'(NB - 1);
    localparam logic [8:0]  LAST_K = 9'(BURST_LEN - 1);

    typedef enum logic [2:0] {IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;
    state_t state, state_n;

    logic [31:0] seed_r, rexp;
    logic [15:0] n, err_n;
    logic [8:0]  k;
    logic [16:0] sum;
    logic [1:0]  inc;
    logic go, aw_hs, w_hs, b_hs, ar_hs, r_hs, last_k, last_n, abort, aborted, unused_ids;

    function automatic logic [AXI_DW-1:0] pat(input logic [31:0] b);
        return {b + 32'd3, b + 32'd2, b + 32'd1, b};
    endfunction

    assign AWID = '0;
    assign ARID = '0;
    assign AWLEN = 8'(BURST_LEN - 1);
    assign ARLEN = 8'(BURST_LEN - 1);
    assign AWSIZE = 3'b100;
    assign ARSIZE = 3'b100;
    assign AWBURST = 2'b01;
    assign ARBURST = 2'b01;
    assign WSTRB = '1;
    assign unused_ids = ^{BID, RID};

    assign go = start && (state == IDLE || state == S_DONE);
    assign aw_hs = AWVALID && AWREADY;
    assign w_hs = WVALID && WREADY;
    assign b_hs = BVALID && BREADY;
    assign ar_hs = ARVALID && ARREADY;
    assign r_hs = RVALID && RREADY;
    assign last_k = k == LAST_K;
    assign last_n = n == LAST_N;

    // Data mismatch, bad RRESP and misplaced RLAST are counted independently on one beat.
    assign inc = b_hs ? {1'b0, BRESP != 2'b00} :
                 r_hs ? 2'(RDATA != pat(rexp)) + 2'(RRESP != 2'b00) + 2'(RLAST != last_k) : 2'd0;
    assign sum = {1'b0, err_cnt} + {15'd0, inc};
    assign err_n = go ? 16'd0 : sum[16] ? 16'hFFFF : sum[15:0];

`ifdef AMI_TG_TIMEOUT_EN
    logic [11:0] wd;
    logic any_hs;
    assign any_hs = aw_hs || w_hs || b_hs || ar_hs || r_hs;
    assign abort = busy && wd == 12'hFFF && !any_hs;
    always_ff @(posedge ACLK)
        wd <= (ARESET || !busy || any_hs) ? 12'd0 : wd + 12'd1;
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge ACLK)
        state <= ARESET ? IDLE : state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE, S_DONE: if (start) state_n = S_AW;
            S_AW:         if (aw_hs) state_n = S_W;
            S_W:          if (w_hs && last_k) state_n = S_B;
            S_B:          if (b_hs) state_n = last_n ? S_AR : S_AW;
            S_AR:         if (ar_hs) state_n = S_R;
            S_R:          if (r_hs && last_k) state_n = last_n ? S_DONE : S_AR;
            default:      state_n = IDLE;
        endcase
        if (abort) state_n = S_DONE;
    end

    // Handshake outputs are registered from the next state so they change only on ACLK.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            {busy, done, pass, aborted} <= '0;
            {AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY} <= '0;
            {AWADDR, ARADDR, WDATA} <= '0;
            {seed_r, rexp, n, k, err_cnt} <= '0;
        end else begin
            busy <= state_n != IDLE && state_n != S_DONE;
            done <= state_n == S_DONE;
            pass <= state_n == S_DONE && err_n == 16'd0 && !aborted && !abort;
            AWVALID <= state_n == S_AW;
            WVALID <= state_n == S_W;
            BREADY <= state_n == S_B;
            ARVALID <= state_n == S_AR;
            RREADY <= state_n == S_R;
            err_cnt <= err_n;
            aborted <= !go && (aborted || abort);
            if (go) begin
                seed_r <= seed;
                n <= '0;
                k <= '0;
                AWADDR <= BASE_ADDR;
                WDATA <= pat(seed);
                WLAST <= LAST_K == 9'd0;
            end
            if (w_hs) begin
                k <= last_k ? 9'd0 : k + 9'd1;
                WDATA <= pat(WDATA[31:0] + 32'd4);
                WLAST <= (last_k ? 9'd0 : k + 9'd1) == LAST_K;
            end
            if (b_hs && last_n) begin
                n <= '0;
                ARADDR <= BASE_ADDR;
                rexp <= seed_r;
            end else if (b_hs) begin
                n <= n + 16'd1;
                AWADDR <= AWADDR + AXI_AW'(BB);
            end
            if (r_hs) begin
                k <= last_k ? 9'd0 : k + 9'd1;
                rexp <= rexp + 32'd4;
            end
            if (r_hs && last_k) begin
                n <= n + 16'd1;
                ARADDR <= ARADDR + AXI_AW'(BB);
            end
        end
    end
endmodule

// File: tb/tb_ami_tg.sv
// tb_ami_tg: scoreboard bench for ami_tg against a behavioural AXI slave with stall and fault injection.
`timescale 1ns/1ps
module tb_ami_tg;
    logic ACLK = 0, ARESET = 1, start = 0;
    logic [31:0] seed = 0;
    logic busy, done, pass;
    logic [15:0] err_cnt;
    logic [3:0] AWID, ARID;
    logic [31:0] AWADDR, ARADDR;
    logic [7:0] AWLEN, ARLEN;
    logic [2:0] AWSIZE, ARSIZE;
    logic [1:0] AWBURST, ARBURST;
    logic AWVALID, ARVALID, WLAST, WVALID, BREADY, RREADY;
    logic AWREADY = 0, WREADY = 0, ARREADY = 0;
    logic [127:0] WDATA;
    logic [15:0] WSTRB;
    logic [3:0] BID = 0, RID = 0;
    logic [1:0] BRESP = 0, RRESP = 0;
    logic BVALID = 0, RVALID = 0, RLAST = 0;
    logic [127:0] RDATA = 0;

    ami_tg dut (
        .ACLK(ACLK), .ARESET(ARESET), .start(start), .seed(seed),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0, fails = 0;
    bit stall = 0, aw_block = 0, bresp_err = 0;
    int corrupt_g = -1, withhold_b = -1;
    logic [127:0] mem [64];
    logic [31:0] q_aw[$], q_ar[$];
    logic [128:0] q_w[$];
    logic [16:0] q_res[$];

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic miss(input string name);
        checks++;
        fails++;
        $display("FAIL %s: got nothing/unexpected expected scoreboard entry", name);
    endtask

    function automatic logic [127:0] pat(input logic [31:0] s, input int g);
        logic [31:0] b;
        b = s + 32'(4 * g);
        return {b + 32'd3, b + 32'd2, b + 32'd1, b};
    endfunction

    task automatic push_run(input logic [31:0] s, input logic pe, input logic [15:0] ee);
        for (int b = 0; b < 4; b++) begin
            q_aw.push_back(32'(b * 256));
            q_ar.push_back(32'(b * 256));
            for (int k = 0; k < 16; k++) q_w.push_back({k == 15, pat(s, b * 16 + k)});
        end
        q_res.push_back({pe, ee});
    endtask

    // Slave: samples handshakes at negedge, applies their effects just after the following posedge.
    initial begin
        int widx, ridx, rcnt;
        bit rs, a, w, b, ar, r, wl;
        logic [31:0] aa, ra;
        logic [127:0] wd;
        widx = 0; ridx = 0; rcnt = 0;
        forever begin
            @(negedge ACLK);
            rs = ARESET; a = AWVALID && AWREADY; aa = AWADDR; w = WVALID && WREADY; wd = WDATA; wl = WLAST;
            b = BVALID && BREADY; ar = ARVALID && ARREADY; ra = ARADDR; r = RVALID && RREADY;
            @(posedge ACLK);
            #1;
            if (rs) begin
                BVALID = 0; RVALID = 0; RLAST = 0;
            end else begin
                if (a) widx = int'(aa >> 4);
                if (w) begin
                    mem[widx % 64] = wd;
                    widx++;
                    if (wl) begin
                        BVALID = 1;
                        BRESP = bresp_err ? 2'b10 : 2'b00;
                        bresp_err = 0;
                    end
                end
                if (b) BVALID = 0;
                if (ar) begin
                    ridx = int'(ra >> 4); rcnt = 0; RVALID = 1;
                end else if (r) begin
                    ridx++; rcnt++;
                    if (rcnt == 16) RVALID = 0;
                end
                RDATA = mem[ridx % 64] ^ ((ridx == corrupt_g) ? 128'h1 : 128'h0);
                RLAST = RVALID && rcnt == 15 && (ridx / 16) != withhold_b;
            end
            AWREADY = !aw_block && (!stall || $urandom_range(1) == 1);
            WREADY = !stall || $urandom_range(1) == 1;
            ARREADY = !stall || $urandom_range(1) == 1;
        end
    end

    // Monitor: pops expectations on every DUT handshake / done edge and checks stalled channels hold.
    logic pv_aw = 0, pr_aw = 0, pv_w = 0, pr_w = 0, pv_ar = 0, pr_ar = 0, pdone = 0;
    logic [31:0] pa_aw, pa_ar;
    logic [128:0] pd_w;
    always @(negedge ACLK) begin
        if (ARESET) begin
            pv_aw = 0; pv_w = 0; pv_ar = 0; pdone = 0;
        end else begin
            if (pv_aw && !pr_aw && !done) chk("aw_hold", {AWVALID, AWADDR}, {1'b1, pa_aw});
            if (pv_w && !pr_w && !done) chk("w_hold", {WVALID, WLAST, WDATA}, {1'b1, pd_w});
            if (pv_ar && !pr_ar && !done) chk("ar_hold", {ARVALID, ARADDR}, {1'b1, pa_ar});
            if (AWVALID && AWREADY) begin
                if (q_aw.size() == 0) miss("aw_extra");
                else chk("aw", {AWID, AWLEN, AWSIZE, AWBURST, AWADDR}, {4'd0, 8'd15, 3'b100, 2'b01, q_aw.pop_front()});
            end
            if (WVALID && WREADY) begin
                if (q_w.size() == 0) miss("w_extra");
                else chk("w", {WSTRB, WLAST, WDATA}, {16'hFFFF, q_w.pop_front()});
            end
            if (ARVALID && ARREADY) begin
                if (q_ar.size() == 0) miss("ar_extra");
                else chk("ar", {ARID, ARLEN, ARSIZE, ARBURST, ARADDR}, {4'd0, 8'd15, 3'b100, 2'b01, q_ar.pop_front()});
            end
            if (done && !pdone) begin
                if (q_res.size() == 0) miss("done_extra");
                else chk("result", {busy, pass, err_cnt}, {1'b0, q_res.pop_front()});
            end
            pdone = done;
            pv_aw = AWVALID; pr_aw = AWREADY; pa_aw = AWADDR;
            pv_w = WVALID; pr_w = WREADY; pd_w = {WLAST, WDATA};
            pv_ar = ARVALID; pr_ar = ARREADY; pa_ar = ARADDR;
        end
    end

    task automatic go(input logic [31:0] s);
        @(posedge ACLK);
        #1;
        seed = s;
        start = 1;
        @(posedge ACLK);
        #1;
        start = 0;
        @(negedge ACLK);
        chk("start_state", {busy, AWVALID, done, pass, err_cnt}, {4'b1100, 16'h0});
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 6000) begin
            @(negedge ACLK);
            n++;
        end
        if (!done) miss("done_timeout");
        @(negedge ACLK);
        chk("drained", 32'(q_aw.size() + q_w.size() + q_ar.size() + q_res.size()), 32'd0);
    endtask

    task automatic run(input logic [31:0] s, input logic pe, input logic [15:0] ee);
        int n;
        push_run(s, pe, ee);
        go(s);
        wait_done(n);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("reset_ctl", {AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY, busy, done, pass}, 9'd0);
        chk("reset_data", {err_cnt, AWADDR, ARADDR, WDATA[63:0]}, 0);
        @(posedge ACLK);
        #1 ARESET = 0;

        run(32'h0, 1'b1, 16'd0);
        chk("mem_beat0", mem[0], 128'h00000003_00000002_00000001_00000000);
        chk("mem_beat63", mem[63], 128'h000000FF_000000FE_000000FD_000000FC);

        stall = 1;
        push_run(32'hDEAD0000, 1'b1, 16'd0);
        go(32'hDEAD0000);
        repeat (20) @(negedge ACLK);
        @(posedge ACLK);
        #1 start = 1;
        @(posedge ACLK);
        #1 start = 0;
        wait_done(n);
        stall = 0;
        chk("mem_dead0", mem[0], 128'hDEAD0003_DEAD0002_DEAD0001_DEAD0000);
        chk("mem_dead37", mem[37], 128'hDEAD0097_DEAD0096_DEAD0095_DEAD0094);

        corrupt_g = 37;
        bresp_err = 1;
        run(32'h0000_1234, 1'b0, 16'd2);
        corrupt_g = -1;

        withhold_b = 2;
        run(32'h0000_0005, 1'b1 & 1'b0, 16'd1);
        withhold_b = -1;

        push_run(32'h0000_0007, 1'b1, 16'd0);
        go(32'h0000_0007);
        n = 0;
        while (!(WVALID && AWADDR == 32'd256) && n < 500) begin
            @(negedge ACLK);
            n++;
        end
        if (n == 500) miss("burst1_wait");
        repeat (3) @(negedge ACLK);
        @(posedge ACLK);
        #1 ARESET = 1;
        @(negedge ACLK);
        @(negedge ACLK);
        chk("midrst_ctl", {AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY, busy, done, pass}, 9'd0);
        chk("midrst_data", {err_cnt, AWADDR, ARADDR, WDATA[63:0]}, 0);
        q_aw.delete(); q_w.delete(); q_ar.delete(); q_res.delete();
        @(posedge ACLK);
        #1 ARESET = 0;
        run(32'h0000_0007, 1'b1, 16'd0);

`ifdef AMI_TG_TIMEOUT_EN
        aw_block = 1;
        q_res.push_back({1'b0, 16'd0});
        go(32'h0000_0009);
        wait_done(n);
        chk("timeout_cycles", 32'(n), 32'd4096);
        aw_block = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
